// File: rtl/aes_mixcol_engine.sv
// aes_mixcol_engine: multi-cycle AES MixColumns over a captured 128-bit state,
// COLS_PER_CYCLE columns per clock. Define AES_MIXCOL_INV_EN to build InvMixColumns.

// One column of (Inv)MixColumns, purely combinational.
module aes_mixcol_unit (
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] p0, p1, p2, p3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

`ifdef AES_MIXCOL_INV_EN
  logic [7:0] u, v;
  // InvMixColumns = MixColumns after a {5,0,4,0} pre-mix; 4*x is xtime applied twice.
  assign u  = inv ? xt(xt(a0 ^ a2)) : 8'h00;
  assign v  = inv ? xt(xt(a1 ^ a3)) : 8'h00;
  assign p0 = a0 ^ u;
  assign p1 = a1 ^ v;
  assign p2 = a2 ^ u;
  assign p3 = a3 ^ v;
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign p0 = a0;
  assign p1 = a1;
  assign p2 = a2;
  assign p3 = a3;
`endif

  assign col_out[31:24] = xt(p0) ^ xt(p1) ^ p1 ^ p2 ^ p3;
  assign col_out[23:16] = p0 ^ xt(p1) ^ xt(p2) ^ p2 ^ p3;
  assign col_out[15:8]  = p0 ^ p1 ^ xt(p2) ^ xt(p3) ^ p3;
  assign col_out[7:0]   = xt(p0) ^ p0 ^ p1 ^ p2 ^ xt(p3);

endmodule

module aes_mixcol_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        inv,
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
  output logic [31:0] state_out0,
  output logic [31:0] state_out1,
  output logic [31:0] state_out2,
  output logic [31:0] state_out3,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fsm_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Handshake: start is a request accepted only when busy=0 (IDLE); while busy=1
  // it is dropped, never queued. done pulses once and marks state_out* valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_t      state;
  logic [1:0]  col;
  logic        inv_r;
  logic [31:0] cap   [4];
  logic [31:0] out_r [4];
  logic [31:0] unit_in  [COLS_PER_CYCLE];
  logic [31:0] unit_out [COLS_PER_CYCLE];

  for (genvar u = 0; u < COLS_PER_CYCLE; u++) begin : g_unit
    assign unit_in[u] = cap[col + 2'(u)];
    aes_mixcol_unit u_col (
      .col_in  (unit_in[u]),
      .inv     (inv_r),
      .col_out (unit_out[u])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      col   <= 2'd0;
      inv_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cap[i]   <= '0;
        out_r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cap[0] <= state0;
            cap[1] <= state1;
            cap[2] <= state2;
            cap[3] <= state3;
            inv_r  <= inv;
            col    <= 2'd0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int u = 0; u < COLS_PER_CYCLE; u++) begin
            out_r[col + 2'(u)] <= unit_out[u];
          end
          if (col == LAST_COL) begin
            col   <= 2'd0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            col <= col + COL_STEP;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          col   <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_out0 = out_r[0];
  assign state_out1 = out_r[1];
  assign state_out2 = out_r[2];
  assign state_out3 = out_r[3];
  assign fsm_state  = state;

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Directed bench for aes_mixcol_engine: three instances (1, 2 and 4 columns per
// clock) sharing clock, reset and data inputs, each with its own start.
module tb_aes_mixcol_engine;

  localparam logic [127:0] A_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] A_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] B_IN  = 128'hd4d4d4d5_2d26314c_00000000_00000000;
  localparam logic [127:0] B_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_00000000;

  logic clk = 1'b0;
  logic reset;
  logic start1, start2, start4, inv;
  logic [31:0] s0, s1, s2, s3;
  logic [127:0] r1, r2, r4;
  logic busy1, busy2, busy4, done1, done2, done4;
  logic [1:0] fs1, fs2, fs4;

  int checks = 0;
  int failures = 0;

  int sel;
  logic sel_busy, sel_done;
  logic [127:0] sel_res;

  always #5 clk = ~clk;

  aes_mixcol_engine #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .inv(inv),
    .state0(s0), .state1(s1), .state2(s2), .state3(s3),
    .state_out0(r1[127:96]), .state_out1(r1[95:64]), .state_out2(r1[63:32]), .state_out3(r1[31:0]),
    .busy(busy1), .done(done1), .fsm_state(fs1));

  aes_mixcol_engine #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .inv(inv),
    .state0(s0), .state1(s1), .state2(s2), .state3(s3),
    .state_out0(r2[127:96]), .state_out1(r2[95:64]), .state_out2(r2[63:32]), .state_out3(r2[31:0]),
    .busy(busy2), .done(done2), .fsm_state(fs2));

  aes_mixcol_engine #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .inv(inv),
    .state0(s0), .state1(s1), .state2(s2), .state3(s3),
    .state_out0(r4[127:96]), .state_out1(r4[95:64]), .state_out2(r4[63:32]), .state_out3(r4[31:0]),
    .busy(busy4), .done(done4), .fsm_state(fs4));

  always_comb begin
    sel_busy = busy1;
    sel_done = done1;
    sel_res  = r1;
    case (sel)
      2: begin sel_busy = busy2; sel_done = done2; sel_res = r2; end
      4: begin sel_busy = busy4; sel_done = done4; sel_res = r4; end
      default: ;
    endcase
  end

  task automatic set_start(input int which, input logic v);
    case (which)
      1: start1 = v;
      2: start2 = v;
      default: start4 = v;
    endcase
  endtask

  // Pulse start for one edge, then sample #1 after each edge; c=1 is the start edge.
  task automatic run_op(input int which, input logic [127:0] data, input logic iv,
                        input int window, output int lat, output int busy_cnt,
                        output int done_cnt, output logic [127:0] res);
    sel = which;
    {s0, s1, s2, s3} = data;
    inv = iv;
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    lat = 0; busy_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= window; c++) begin
      if (sel_busy) busy_cnt++;
      if (sel_done) begin
        done_cnt++;
        if (lat == 0) lat = c;
      end
      @(posedge clk); #1;
    end
    res = sel_res;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start1 = 1'b0; start2 = 1'b0; start4 = 1'b0; inv = 1'b0;
    {s0, s1, s2, s3} = A_IN;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy2 got=%b exp=0", busy2); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done1 got=%b exp=0", done1); end
    checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL reset_done2 got=%b exp=0", done2); end
    checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL reset_done4 got=%b exp=0", done4); end
    checks++; if (r1 !== 128'h0) begin failures++; $display("FAIL reset_out1 got=%h exp=0", r1); end
    checks++; if (r2 !== 128'h0) begin failures++; $display("FAIL reset_out2 got=%h exp=0", r2); end
    checks++; if (r4 !== 128'h0) begin failures++; $display("FAIL reset_out4 got=%h exp=0", r4); end
    checks++; if (fs1 !== 2'd0) begin failures++; $display("FAIL reset_fsm1 got=%0d exp=0", fs1); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fwd_cpc1();
    int lat, bc, dc;
    logic [127:0] res;
    run_op(1, A_IN, 1'b0, 10, lat, bc, dc, res);
    checks++; if (res !== A_OUT) begin failures++; $display("FAIL fwd1_result got=%h exp=%h", res, A_OUT); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL fwd1_latency got=%0d exp=5", lat); end
    checks++; if (bc !== 5) begin failures++; $display("FAIL fwd1_busy_cycles got=%0d exp=5", bc); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL fwd1_done_count got=%0d exp=1", dc); end
  endtask

  task automatic test_fwd_cpc4();
    int lat, bc, dc;
    logic [127:0] res;
    run_op(4, B_IN, 1'b0, 8, lat, bc, dc, res);
    checks++; if (res !== B_OUT) begin failures++; $display("FAIL fwd4_result got=%h exp=%h", res, B_OUT); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL fwd4_latency got=%0d exp=2", lat); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL fwd4_busy_cycles got=%0d exp=2", bc); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL fwd4_done_count got=%0d exp=1", dc); end
  endtask

  // With the inverse built, undo test 1; without it, inv=1 must still give the forward result.
  task automatic test_inv_cpc2();
    int lat, bc, dc;
    logic [127:0] res, exp_res;
`ifdef AES_MIXCOL_INV_EN
    exp_res = A_IN;
    run_op(2, A_OUT, 1'b1, 8, lat, bc, dc, res);
`else
    exp_res = A_OUT;
    run_op(2, A_IN, 1'b1, 8, lat, bc, dc, res);
`endif
    checks++; if (res !== exp_res) begin failures++; $display("FAIL inv2_result got=%h exp=%h", res, exp_res); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL inv2_latency got=%0d exp=3", lat); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL inv2_done_count got=%0d exp=1", dc); end
  endtask

  task automatic test_start_while_busy();
    int lat, dc;
    sel = 1;
    {s0, s1, s2, s3} = A_IN;
    inv = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    {s0, s1, s2, s3} = B_IN;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0; dc = 0;
    for (int c = 2; c <= 12; c++) begin
      if (sel_done) begin
        dc++;
        if (lat == 0) lat = c;
      end
      @(posedge clk); #1;
    end
    checks++; if (r1 !== A_OUT) begin failures++; $display("FAIL busy_start_result got=%h exp=%h", r1, A_OUT); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", dc); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL busy_start_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, dc;
    logic [127:0] res;
    sel = 1;
    {s0, s1, s2, s3} = B_IN;
    inv = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done1); end
    checks++; if (r1 !== 128'h0) begin failures++; $display("FAIL midrst_out got=%h exp=0", r1); end
    checks++; if (fs1 !== 2'd0) begin failures++; $display("FAIL midrst_fsm got=%0d exp=0", fs1); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    dc = 0; bc = 0;
    for (int c = 0; c < 10; c++) begin
      if (done1) dc++;
      if (busy1) bc++;
      @(posedge clk); #1;
    end
    checks++; if (dc !== 0) begin failures++; $display("FAIL midrst_stray_done got=%0d exp=0", dc); end
    checks++; if (bc !== 0) begin failures++; $display("FAIL midrst_stray_busy got=%0d exp=0", bc); end
    run_op(1, B_IN, 1'b0, 10, lat, bc, dc, res);
    checks++; if (res !== B_OUT) begin failures++; $display("FAIL midrst_restart_result got=%h exp=%h", res, B_OUT); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL midrst_restart_latency got=%0d exp=5", lat); end
  endtask

  // start held high: a new operation begins at every IDLE cycle, one state per N+2 cycles.
  task automatic test_back_to_back();
    int first, second, dc;
    sel = 4;
    {s0, s1, s2, s3} = A_IN;
    inv = 1'b0;
    start4 = 1'b1;
    @(posedge clk); #1;
    first = 0; second = 0; dc = 0;
    for (int c = 1; c <= 9; c++) begin
      if (done4) begin
        dc++;
        if (dc == 1) first = c;
        if (dc == 2) second = c;
      end
      @(posedge clk); #1;
    end
    start4 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (dc !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", dc); end
    checks++; if (first !== 2) begin failures++; $display("FAIL b2b_first_done got=%0d exp=2", first); end
    checks++; if (second - first !== 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", second - first); end
    checks++; if (r4 !== A_OUT) begin failures++; $display("FAIL b2b_result got=%h exp=%h", r4, A_OUT); end
  endtask

  initial begin
    sel = 1;
    test_reset();
    test_fwd_cpc1();
    test_fwd_cpc4();
    test_inv_cpc2();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
